// File: rtl/qos_alloc_pkg.sv
// Shared sizing and FSM encoding for the QoS ID allocator.
package qos_alloc_pkg;

  localparam int NUM_IDS = 16;
  localparam int ID_W    = 4;
  localparam int QOS_W   = 3;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    DONE
  } alloc_state_t;

endpackage

// File: rtl/qos_id_alloc_prio_enc.sv
// Lowest-set-bit encoder: returns the index of the lowest set bit of vec
// and whether any bit is set. Purely combinational.
module prio_enc
  import qos_alloc_pkg::*;
#(
  parameter int N = NUM_IDS,
  parameter int W = ID_W
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         any
);

  // seen[k] is set when any of vec[k-1:0] is set; first[] is one-hot on the
  // lowest set bit, so the index can be built by OR-ing without priority.
  logic [N:0]   seen;
  logic [N-1:0] first;

  assign seen[0] = 1'b0;

  for (genvar gi = 0; gi < N; gi++) begin : g_chain
    assign seen[gi+1] = seen[gi] | vec[gi];
    assign first[gi]  = vec[gi] & ~seen[gi];
  end

  // Encode the one-hot lowest-bit vector into a binary index.
  always_comb begin
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (first[i]) begin
        idx = idx | W'(i);
      end
    end
  end

  assign any = seen[N];

endmodule

// File: rtl/qos_id_alloc.sv
// QoS ID allocator: grants the lowest free ID from a 16-entry pool to each
// accepted request, frees IDs on completion, and notifies the tracker through
// registered write (allocate) and read (free) pulses. A drain FSM blocks new
// grants until every outstanding ID has completed.
module qos_id_alloc
  import qos_alloc_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             req_vld,
  input  logic [QOS_W-1:0] req_qos,
  output logic             req_rdy,
  output logic [ID_W-1:0]  req_id,
  input  logic             cpl_vld,
  input  logic [ID_W-1:0]  cpl_id,
  input  logic             drain,
  output logic             wr_vld,
  output logic [ID_W-1:0]  wr_id,
  output logic [QOS_W-1:0] wr_qos,
  output logic             rd_vld,
  output logic [ID_W-1:0]  rd_id,
  output logic [ID_W:0]    busy_cnt,
  output logic             idle,
  output logic             err_cpl
);

  alloc_state_t      state_reg, state_next;
  logic [NUM_IDS-1:0] alloc_map_reg, alloc_map_next;
  logic [ID_W:0]      busy_cnt_reg, busy_cnt_next;

  logic               wr_vld_reg;
  logic [ID_W-1:0]    wr_id_reg;
  logic [QOS_W-1:0]   wr_qos_reg;
  logic               rd_vld_reg;
  logic [ID_W-1:0]    rd_id_reg;
  logic               err_cpl_reg;

  logic [ID_W-1:0]    grant_id;
  logic               any_free;
  logic               grant;
  logic               cpl_hit;
  logic               cpl_ok;
  logic               cpl_bad;

  // Grant decision uses only the registered map, so an ID freed this cycle
  // cannot be handed out again until the next cycle.
  prio_enc #(
    .N (NUM_IDS),
    .W (ID_W)
  ) u_prio_enc (
    .vec (~alloc_map_reg),
    .idx (grant_id),
    .any (any_free)
  );

  assign req_rdy = (state_reg == RUN) && any_free;
  assign req_id  = grant_id;
  assign grant   = req_vld && req_rdy;

  // A completion is valid only for an ID that is currently allocated; the ID
  // granted this same cycle is still clear in the map and therefore invalid.
  assign cpl_hit = alloc_map_reg[cpl_id];
  assign cpl_ok  = cpl_vld && cpl_hit;
  assign cpl_bad = cpl_vld && !cpl_hit;

  // Set and clear can never hit the same bit: set needs it clear, clear needs it set.
  for (genvar gi = 0; gi < NUM_IDS; gi++) begin : g_map
    assign alloc_map_next[gi] =
        (alloc_map_reg[gi] | (grant && (grant_id == ID_W'(gi))))
      & ~(cpl_ok && (cpl_id == ID_W'(gi)));
  end

  assign busy_cnt_next = busy_cnt_reg + (ID_W+1)'(grant) - (ID_W+1)'(cpl_ok);

  // Drain FSM next state; DRAIN ignores drain dropping until the pool is empty.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RUN:     if (drain) state_next = DRAIN;
      DRAIN:   if (busy_cnt_reg == '0) state_next = DONE;
      DONE:    if (!drain) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  // FSM, pool map and outstanding count registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= RUN;
      alloc_map_reg <= '0;
      busy_cnt_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      alloc_map_reg <= alloc_map_next;
      busy_cnt_reg  <= busy_cnt_next;
    end
  end

  // Tracker notification pulses (one cycle each) and sticky completion error.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_vld_reg  <= 1'b0;
      wr_id_reg   <= '0;
      wr_qos_reg  <= '0;
      rd_vld_reg  <= 1'b0;
      rd_id_reg   <= '0;
      err_cpl_reg <= 1'b0;
    end else begin
      wr_vld_reg <= grant;
      if (grant) begin
        wr_id_reg  <= grant_id;
        wr_qos_reg <= req_qos;
      end
      rd_vld_reg <= cpl_ok;
      if (cpl_ok) begin
        rd_id_reg <= cpl_id;
      end
      if (cpl_bad) begin
        err_cpl_reg <= 1'b1;
      end
    end
  end

  assign wr_vld   = wr_vld_reg;
  assign wr_id    = wr_id_reg;
  assign wr_qos   = wr_qos_reg;
  assign rd_vld   = rd_vld_reg;
  assign rd_id    = rd_id_reg;
  assign busy_cnt = busy_cnt_reg;
  assign idle     = (state_reg == DONE);
  assign err_cpl  = err_cpl_reg;

endmodule

// File: tb/tb_qos_id_alloc.sv
// Directed bench for qos_id_alloc. Stimulus pushes expected tracker pulses
// (with the cycle they must appear in) into queues; a negedge monitor pops
// and compares whenever wr_vld or rd_vld is seen.
module tb_qos_id_alloc;

  logic       clk;
  logic       rst;
  logic       req_vld;
  logic [2:0] req_qos;
  logic       req_rdy;
  logic [3:0] req_id;
  logic       cpl_vld;
  logic [3:0] cpl_id;
  logic       drain;
  logic       wr_vld;
  logic [3:0] wr_id;
  logic [2:0] wr_qos;
  logic       rd_vld;
  logic [3:0] rd_id;
  logic [4:0] busy_cnt;
  logic       idle;
  logic       err_cpl;

  qos_id_alloc dut (
    .clk      (clk),
    .rst      (rst),
    .req_vld  (req_vld),
    .req_qos  (req_qos),
    .req_rdy  (req_rdy),
    .req_id   (req_id),
    .cpl_vld  (cpl_vld),
    .cpl_id   (cpl_id),
    .drain    (drain),
    .wr_vld   (wr_vld),
    .wr_id    (wr_id),
    .wr_qos   (wr_qos),
    .rd_vld   (rd_vld),
    .rd_id    (rd_id),
    .busy_cnt (busy_cnt),
    .idle     (idle),
    .err_cpl  (err_cpl)
  );

  typedef struct {
    int         cyc;
    logic [3:0] id;
    logic [2:0] qos;
  } exp_t;

  exp_t exp_wr[$];
  exp_t exp_rd[$];

  int vec_cnt    = 0;
  int miscmp_cnt = 0;
  int cyc        = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miscmp_cnt++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every tracker pulse must match the oldest expected entry,
  // including the cycle in which it appears.
  always @(negedge clk) begin
    exp_t e;
    if (wr_vld === 1'b1) begin
      if (exp_wr.size() == 0) begin
        vec_cnt++;
        miscmp_cnt++;
        $display("FAIL wr_unexpected: got wr_id=%0d, expected no allocate pulse (cycle %0d)", wr_id, cyc);
      end else begin
        e = exp_wr.pop_front();
        chk("wr_cycle", cyc, e.cyc);
        chk("wr_id", wr_id, e.id);
        chk("wr_qos", wr_qos, e.qos);
      end
    end
    if (rd_vld === 1'b1) begin
      if (exp_rd.size() == 0) begin
        vec_cnt++;
        miscmp_cnt++;
        $display("FAIL rd_unexpected: got rd_id=%0d, expected no free pulse (cycle %0d)", rd_id, cyc);
      end else begin
        e = exp_rd.pop_front();
        chk("rd_cycle", cyc, e.cyc);
        chk("rd_id", rd_id, e.id);
      end
    end
  end

  // Present a request that must be granted eid; the wr pulse shows next cycle.
  task automatic drive_req(input logic [2:0] q, input logic [3:0] eid);
    exp_t e;
    req_vld = 1'b1;
    req_qos = q;
    #0;
    chk("req_rdy_grant", req_rdy, 1);
    chk("req_id_grant", req_id, eid);
    e.cyc = cyc + 1;
    e.id  = eid;
    e.qos = q;
    exp_wr.push_back(e);
  endtask

  // Present a completion; ok says whether a free pulse is expected.
  task automatic drive_cpl(input logic [3:0] id, input bit ok);
    exp_t e;
    cpl_vld = 1'b1;
    cpl_id  = id;
    if (ok) begin
      e.cyc = cyc + 1;
      e.id  = id;
      e.qos = '0;
      exp_rd.push_back(e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    req_vld = 1'b0;
    cpl_vld = 1'b0;
  endtask

  task automatic check_reset();
    chk("rst_req_rdy", req_rdy, 1);
    chk("rst_req_id", req_id, 0);
    chk("rst_busy_cnt", busy_cnt, 0);
    chk("rst_idle", idle, 0);
    chk("rst_err_cpl", err_cpl, 0);
    chk("rst_wr_vld", wr_vld, 0);
    chk("rst_wr_id", wr_id, 0);
    chk("rst_wr_qos", wr_qos, 0);
    chk("rst_rd_vld", rd_vld, 0);
    chk("rst_rd_id", rd_id, 0);
  endtask

  initial begin
    rst     = 1'b1;
    req_vld = 1'b0;
    req_qos = '0;
    cpl_vld = 1'b0;
    cpl_id  = '0;
    drain   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset();
    rst = 1'b0;

    // Fill the pool: IDs 0..15 in order, qos 0..7,0..7.
    for (int i = 0; i < 16; i++) begin
      drive_req(3'(i % 8), 4'(i));
      step();
      chk("busy_fill", busy_cnt, i + 1);
    end
    chk("rdy_full", req_rdy, 0);

    // Free ID 5 from a full pool; it becomes the next grant.
    drive_cpl(4'd5, 1'b1);
    step();
    chk("busy_free5", busy_cnt, 15);
    chk("rdy_free5", req_rdy, 1);
    chk("id_free5", req_id, 5);

    drive_cpl(4'd3, 1'b1);
    step();
    chk("busy_free3", busy_cnt, 14);
    chk("id_free3", req_id, 3);

    // Grant 3 and free 1 in the same cycle.
    drive_req(3'd6, 4'd3);
    drive_cpl(4'd1, 1'b1);
    step();
    chk("both_wr_vld", wr_vld, 1);
    chk("both_rd_vld", rd_vld, 1);
    chk("busy_both", busy_cnt, 14);
    chk("id_after_both", req_id, 1);

    drive_cpl(4'd9, 1'b1);
    step();
    chk("busy_free9", busy_cnt, 13);

    // Completion of an ID that is no longer allocated.
    drive_cpl(4'd9, 1'b0);
    step();
    chk("err_set", err_cpl, 1);
    chk("rd_vld_bad", rd_vld, 0);
    chk("busy_bad", busy_cnt, 13);
    chk("id_bad", req_id, 1);
    step();
    step();
    chk("err_sticky", err_cpl, 1);

    // Completion of the ID granted in the same cycle takes the invalid path.
    drive_req(3'd2, 4'd1);
    drive_cpl(4'd1, 1'b0);
    step();
    chk("busy_samecyc", busy_cnt, 14);
    chk("rd_vld_samecyc", rd_vld, 0);
    chk("id_samecyc", req_id, 5);
    chk("err_still", err_cpl, 1);

    // Reset clears the sticky error and the pool.
    rst = 1'b1;
    step();
    check_reset();
    rst = 1'b0;

    // Drain with 4 outstanding.
    for (int i = 0; i < 4; i++) begin
      drive_req(3'(i + 4), 4'(i));
      step();
    end
    drain = 1'b1;
    step();
    chk("drain_rdy", req_rdy, 0);
    chk("drain_idle", idle, 0);
    chk("drain_busy", busy_cnt, 4);

    // A request during DRAIN must not be granted.
    req_vld = 1'b1;
    req_qos = 3'd1;
    drive_cpl(4'd0, 1'b1);
    step();
    chk("drain_busy3", busy_cnt, 3);
    chk("drain_wr_vld", wr_vld, 0);

    drive_cpl(4'd1, 1'b1);
    drain = 1'b0;
    step();
    chk("drain_busy2", busy_cnt, 2);

    drive_cpl(4'd2, 1'b1);
    step();
    chk("drain_hold_rdy", req_rdy, 0);
    chk("drain_hold_idle", idle, 0);

    drain = 1'b1;
    drive_cpl(4'd3, 1'b1);
    step();
    chk("drain_busy0", busy_cnt, 0);
    chk("drain_idle_b0", idle, 0);
    step();
    chk("done_idle", idle, 1);
    chk("done_rdy", req_rdy, 0);
    step();
    chk("done_idle_hold", idle, 1);
    drain = 1'b0;
    step();
    chk("run_idle", idle, 0);
    chk("run_rdy", req_rdy, 1);
    chk("run_id", req_id, 0);

    // Drain with an empty pool: DRAIN after E, DONE after E+1.
    drain = 1'b1;
    step();
    chk("empty_drain_idle", idle, 0);
    chk("empty_drain_rdy", req_rdy, 0);
    step();
    chk("empty_done_idle", idle, 1);
    drain = 1'b0;
    step();
    chk("empty_run_idle", idle, 0);
    chk("empty_run_rdy", req_rdy, 1);

    // Reset with 7 outstanding, a pending wr pulse and err_cpl set.
    for (int i = 0; i < 7; i++) begin
      drive_req(3'(7 - i), 4'(i));
      if (i == 0) drive_cpl(4'd12, 1'b0);
      step();
    end
    chk("pre_rst_busy", busy_cnt, 7);
    chk("pre_rst_wr_vld", wr_vld, 1);
    chk("pre_rst_err", err_cpl, 1);
    rst = 1'b1;
    step();
    check_reset();
    rst = 1'b0;

    @(negedge clk);
    #1;
    chk("wr_queue_empty", exp_wr.size(), 0);
    chk("rd_queue_empty", exp_rd.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
    $finish;
  end

endmodule

// File: doc/qos_id_alloc.md
# qos_id_alloc

Upstream ID allocator for the QoS tracker. It accepts QoS-tagged requests over a valid/ready handshake and assigns each one the lowest-numbered free ID from a 16-entry pool. It releases IDs on completion and drives the tracker's write port (`wr_vld/wr_id/wr_qos`) and read/free port (`rd_vld/rd_id`) from registers. A drain state machine stops new allocations until every outstanding ID has completed.

## Interface
- `NUM_IDS`, 16, size of the ID pool.
- `ID_W`, 4, ID width; equals log2(`NUM_IDS`).
- `QOS_W`, 3, QoS width.

- `clk`  in  1  single clock; everything is sampled on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_vld`  in  1  request valid.
- `req_qos`  in  QOS_W  request QoS.
- `req_rdy`  out  1  request accepted when `req_vld && req_rdy`.
- `req_id`  out  ID_W  ID granted to the current request; combinational, meaningful only when `req_rdy=1`.
- `cpl_vld`  in  1  completion valid.
- `cpl_id`  in  ID_W  ID being completed.
- `drain`  in  1  level request to stop allocating and wait for the pool to empty.
- `wr_vld`, `wr_id`, `wr_qos`  out  1/ID_W/QOS_W  registered allocate notification to the tracker.
- `rd_vld`, `rd_id`  out  1/ID_W  registered free notification to the tracker.
- `busy_cnt`  out  ID_W+1  number of allocated IDs, 0..16.
- `idle`  out  1  high in state DONE.
- `err_cpl`  out  1  sticky flag: a completion arrived for an ID that was not allocated.

## Operation
- Internal state:
  - `alloc_map[NUM_IDS]`: 1 means the ID is allocated.
  - `busy_cnt`.
  - FSM state: RUN, DRAIN, DONE.
- Grant:
  - `req_rdy = (state==RUN) && (~alloc_map != 0)`.
  - `req_id` = index of the lowest clear bit of `alloc_map`.
- Handshake:
  - Sets `alloc_map[req_id]`.
  - Registers `wr_vld=1`, `wr_id=req_id`, `wr_qos=req_qos`.
  - `req_qos` is passed through unchanged.
- Valid completion (`cpl_vld` with `alloc_map[cpl_id]=1`):
  - Clears the bit.
  - Registers `rd_vld=1`, `rd_id=cpl_id`.
- Invalid completion (bit already clear):
  - No state change, `rd_vld` stays 0.
  - Sets `err_cpl`, which stays set until `rst`.
- `req_rdy` and `req_id` are computed from the current `alloc_map`. An ID freed in cycle N is never re-granted in cycle N.
- A completion for the ID granted in the same cycle always takes the invalid-completion path, because that bit was clear.
- `busy_cnt` next value = `busy_cnt + grant - valid_cpl`. Allocate plus free in the same cycle leaves it unchanged.
- `busy_cnt` never exceeds 16 or goes below 0: grant requires a free ID, and a free requires an allocated one.
- FSM transitions:
  - RUN → DRAIN when `drain=1`.
  - DRAIN → DONE when `busy_cnt==0`, evaluated on the registered value.
  - DONE → RUN when `drain=0`.
  - DRAIN stays in DRAIN if `drain` drops early; the pool must empty first.
- `req_rdy=0` in DRAIN and DONE. Completions are processed in every state.
- Pool full (16 allocated): `req_rdy=0`; no back-pressure on completions.

## Timing
- Reset values:
  - `alloc_map=0`, `busy_cnt=0`.
  - State RUN, so `req_rdy=1` and `req_id=0` after reset.
  - `wr_vld=0`, `wr_id=0`, `wr_qos=0`.
  - `rd_vld=0`, `rd_id=0`.
  - `idle=0`, `err_cpl=0`.
- Handshake sampled at edge E:
  - `wr_*` valid for exactly one cycle after E.
  - The tracker stores the entry at E+1.
- Completion sampled at edge E: `rd_*` valid for exactly one cycle after E.
- Ordering: free of ID k at edge E, then earliest re-grant of k sampled at E+1, so the tracker sees `rd` for k strictly before the new `wr` for k.
- `wr_vld` and `rd_vld` may be high in the same cycle, always for different IDs.
- Drain with an empty pool:
  - `drain` asserted at E: state DRAIN after E.
  - State DONE after E+1; `idle=1` from that cycle on.
- `rst` mid-operation: everything returns to reset values at the next edge. Pending `wr`/`rd` pulses are dropped.

## Structure
- Package `qos_alloc_pkg` holds:
  - `NUM_IDS`, `ID_W`, `QOS_W` localparams.
  - FSM enum `alloc_state_t {RUN, DRAIN, DONE}`.
- Sub-module `prio_enc`: NUM_IDS-bit lowest-set-bit encoder.
  - Input is `~alloc_map`.
  - Outputs are the index and an any-set flag.
  - It is purely combinational.
- Everything else lives in `qos_id_alloc`.

## Test plan
- Reset, then 16 back-to-back requests with qos=0..7,0..7:
  - `req_id` = 0..15 in order.
  - `wr_qos` matches each request, one cycle later.
  - `busy_cnt=16`, then `req_rdy=0`.
- Full pool, complete ID 5:
  - `rd_vld`/`rd_id=5` next cycle.
  - `req_rdy=1` with `req_id=5` from that cycle.
  - `busy_cnt` goes 16→15.
- Same cycle: grant ID 3 and complete allocated ID 1:
  - `wr_id=3` and `rd_id=1` in the same cycle.
  - `busy_cnt` unchanged.
- Completion of unallocated ID 9:
  - No `rd_vld`.
  - `err_cpl=1`, and it persists until `rst`.
  - `busy_cnt` unchanged.
- 4 outstanding, raise `drain`:
  - `req_rdy=0` immediately after the transition.
  - Complete all 4.
  - `idle=1` one cycle after `busy_cnt` reaches 0.
  - Drop `drain`: RUN, `req_rdy=1`.
- `rst` asserted with 7 outstanding and a pending `wr_vld`:
  - Next cycle every output is at its reset value.
  - `req_id=0`.
